// File: rtl/div_share_ctrl.sv
// Round-robin front end sharing one iterative unsigned divider among NREQ requesters.
// Zero divisors are answered locally; the divider only runs for nonzero divisors.
module div_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int W     = 16,
    parameter int STEPS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_id,
    output logic [W-1:0]      rsp_q,
    output logic [W-1:0]      rsp_r,
    output logic              rsp_dbz,
    output logic              busy,
    output logic              div_ld,
    output logic [W-1:0]      div_a,
    output logic [W-1:0]      div_b,
    input  logic [W-1:0]      div_q,
    input  logic [W-1:0]      div_r
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  gnt;
    logic [IW-1:0]  idx;
    logic           any;
    logic [W-1:0]   ga;
    logic [W-1:0]   gb;

    // Search upward from the slot after the last grant, wrapping.
    always_comb begin
        any = 1'b0;
        gnt = ptr;
        idx = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                gnt = idx;
            end
        end
    end

    assign ga = req_a[int'(gnt)*W +: W];
    assign gb = req_b[int'(gnt)*W +: W];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_nx = (gb == '0) ? RESP : LOAD;
                end
            end
            LOAD: state_nx = RUN;
            RUN: begin
                if (cnt == CW'(STEPS - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && any) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign div_ld    = (state == LOAD);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= IW'(NREQ - 1);
            div_a   <= '0;
            div_b   <= '0;
            rsp_id  <= '0;
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_dbz <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        div_a  <= ga;
                        div_b  <= gb;
                        rsp_id <= 3'(gnt);
                        ptr    <= gnt;
                        if (gb == '0) begin
                            rsp_q   <= '1;
                            rsp_r   <= ga;
                            rsp_dbz <= 1'b1;
                        end else begin
                            rsp_dbz <= 1'b0;
                        end
                    end
                end
                LOAD: cnt <= '0;
                RUN:  cnt <= cnt + 1'b1;
                DONE: begin
                    rsp_q <= div_q;
                    rsp_r <= div_r;
                end
                RESP: ;
                default: ;
            endcase
        end
    end

endmodule
